// File: rtl/sqrt_pkg.sv
// Shared definitions for the square rooter and square restorer: FSM states,
// default widths and the result payload.
package sqrt_pkg;

    localparam int unsigned ROOT_W    = 8;
    localparam int unsigned NUM_W     = 8;
    localparam int unsigned ROOT_IN_W = 16;
    localparam int unsigned BUF_W     = 8;
    localparam int unsigned ACC_W     = 16;
    localparam int unsigned STEP_W    = 3;
    localparam int unsigned BUF_MIN   = 4;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SHIFT,
        DONE
    } state_t;

    typedef struct packed {
        logic [NUM_W-1:0] num;
        logic             sat;
        logic             err;
    } result_t;

endpackage

// File: rtl/square_restorer_if.sv
// Request/result bus of the square restorer.
interface square_restorer_if;
    import sqrt_pkg::*;

    logic                 start;
    logic [ROOT_IN_W-1:0] root;
    logic [BUF_W-1:0]     buffer_in;
    logic                 busy;
    logic                 done;
    logic [NUM_W-1:0]     num_out;
    logic                 sat;
    logic                 err;

    modport master (output start, root, buffer_in, input busy, done, num_out, sat, err);
    modport slave  (input start, root, buffer_in, output busy, done, num_out, sat, err);

endinterface

// File: rtl/square_denorm.sv
// Combinational denormalisation: shifts root^2 right by 2*buffer, saturates to NUM_W.
// Define SQUARE_RESTORER_ROUND_EN for round-half-up instead of truncation.
module square_denorm
    import sqrt_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [BUF_W-1:0] buffer,
    input  logic             err,
    output logic [NUM_W-1:0] num_c,
    output logic             sat_c
);

    logic [BUF_W:0] sh;
    logic [ACC_W:0] res;
`ifdef SQUARE_RESTORER_ROUND_EN
    logic [ACC_W:0] rnd;
`endif

    // Doubling in one extra bit so large buffers cannot wrap into a small shift
    assign sh = {buffer, 1'b0};

    always_comb begin
        res = '0;
`ifdef SQUARE_RESTORER_ROUND_EN
        rnd = '0;
        // Beyond a shift of 16 the half-LSB term already exceeds any acc
        if (sh <= (BUF_W+1)'(ACC_W)) begin
            if (sh != '0) begin
                rnd = (ACC_W+1)'(1) << (sh - (BUF_W+1)'(1));
            end
            res = ((ACC_W+1)'(acc) + rnd) >> sh;
        end
`else
        if (sh < (BUF_W+1)'(ACC_W)) begin
            res = (ACC_W+1)'(acc >> sh);
        end
`endif
        sat_c = |res[ACC_W:NUM_W];
        num_c = sat_c ? '1 : res[NUM_W-1:0];
        if (err) begin
            num_c = '0;
            sat_c = 1'b0;
        end
    end

endmodule

// File: rtl/square_restorer.sv
// Sequential squarer: 8-cycle shift-add of root*root, then denormalise by 2*buffer.
// Rounding option selected by SQUARE_RESTORER_ROUND_EN (see square_denorm).
module square_restorer
    import sqrt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    square_restorer_if.slave  bus
);

    state_t              state, state_nxt;
    logic [ROOT_W-1:0]   mcand;
    logic [ROOT_W-1:0]   mplier;
    logic [STEP_W-1:0]   step;
    logic [ACC_W-1:0]    acc;
    logic [BUF_W-1:0]    buf_q;
    logic                err_lat;
    logic [NUM_W-1:0]    num_c;
    logic                sat_c;
    result_t             res_q;
    result_t             out_q;
    logic                busy_q;
    logic                done_q;

    square_denorm u_denorm (
        .acc    (acc),
        .buffer (buf_q),
        .err    (err_lat),
        .num_c  (num_c),
        .sat_c  (sat_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = MUL;
            MUL:     if (step == STEP_W'(ROOT_W - 1)) state_nxt = SHIFT;
            SHIFT:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath; results are staged in res_q and only published with done
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            step    <= '0;
            acc     <= '0;
            buf_q   <= '0;
            err_lat <= 1'b0;
            res_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            done_q <= (state == DONE);
            case (state)
                IDLE: if (bus.start) begin
                    mcand   <= bus.root[ROOT_W-1:0];
                    mplier  <= bus.root[ROOT_W-1:0];
                    buf_q   <= bus.buffer_in;
                    err_lat <= |bus.root[ROOT_IN_W-1:ROOT_W];
                    acc     <= '0;
                    step    <= '0;
                end
                MUL: begin
                    if (mplier[step]) acc <= acc + (ACC_W'(mcand) << step);
                    step <= step + STEP_W'(1);
                end
                SHIFT: res_q <= '{num: num_c, sat: sat_c, err: err_lat};
                DONE:  out_q <= res_q;
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.num_out = out_q.num;
    assign bus.sat     = out_q.sat;
    assign bus.err     = out_q.err;

endmodule
